// File: rtl/fpga_ram_engine.sv
// fpga_ram_engine
//   Bus initiator for the on-chip RAM request port. It runs FILL or CHECK block operations over
//   a programmable address window. The expected word at address a is pattern ^ {20'h0, a}.
//   FILL writes that word. CHECK reads each word back, compares it and counts mismatches.
//
// Optional feature macro: MEM_ENGINE_CHECKSUM_EN
//   When defined, adds checksum_o. This is the mod-2^32 sum of every transferred word.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   start_i, op_i         command strobe (IDLE only); 0 = FILL, 1 = CHECK
//   base_i, length_i      first word address; word count 0..4096
//   pattern_i             data seed
//   busy_o, done_o        operation in progress; one-cycle end pulse (also on abort)
//   err_count_o           CHECK mismatch count
//   first_err_addr_o      address of the first mismatch
//   err_flag_o            at least one mismatch seen
//   timeout_o             last operation aborted waiting for mem_ready_i
//   checksum_o            (MEM_ENGINE_CHECKSUM_EN only) sum of transferred words
//   mem_cs_o, mem_we_o    RAM chip select; byte write enables
//   mem_address_o         RAM word address
//   mem_write_data_o      RAM write data
//   mem_read_data_i       RAM read data
//   mem_ready_i           RAM access acknowledge
module fpga_ram_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        op_i,
    input  logic [11:0] base_i,
    input  logic [12:0] length_i,
    input  logic [31:0] pattern_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [12:0] err_count_o,
    output logic [11:0] first_err_addr_o,
    output logic        err_flag_o,
    output logic        timeout_o,
`ifdef MEM_ENGINE_CHECKSUM_EN
    output logic [31:0] checksum_o,
`endif
    output logic        mem_cs_o,
    output logic [3:0]  mem_we_o,
    output logic [11:0] mem_address_o,
    output logic [31:0] mem_write_data_o,
    input  logic [31:0] mem_read_data_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

    // Index of the last REQ cycle before a stalled access is abandoned.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [12:0] remain_q, remain_d;
    logic [31:0] pattern_q, pattern_d;
    logic [7:0]  wait_q, wait_d;
    logic [12:0] err_count_q, err_count_d;
    logic [11:0] first_err_addr_q, first_err_addr_d;
    logic        err_flag_q, err_flag_d;
    logic        timeout_q, timeout_d;
`ifdef MEM_ENGINE_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;
`endif

    logic [31:0] expected;
    logic        ready_ok;
    logic        mismatch;

    assign expected = pattern_q ^ {20'h0, addr_q};
    // A ready seen in the first REQ cycle may be left over from the previous access.
    assign ready_ok = mem_ready_i && (wait_q != 8'd0);
    assign mismatch = (mem_read_data_i != expected);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            op_q             <= 1'b0;
            addr_q           <= 12'h0;
            remain_q         <= 13'h0;
            pattern_q        <= 32'h0;
            wait_q           <= 8'h0;
            err_count_q      <= 13'h0;
            first_err_addr_q <= 12'h0;
            err_flag_q       <= 1'b0;
            timeout_q        <= 1'b0;
`ifdef MEM_ENGINE_CHECKSUM_EN
            checksum_q       <= 32'h0;
`endif
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            addr_q           <= addr_d;
            remain_q         <= remain_d;
            pattern_q        <= pattern_d;
            wait_q           <= wait_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            err_flag_q       <= err_flag_d;
            timeout_q        <= timeout_d;
`ifdef MEM_ENGINE_CHECKSUM_EN
            checksum_q       <= checksum_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        addr_d           = addr_q;
        remain_d         = remain_q;
        pattern_d        = pattern_q;
        wait_d           = wait_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        err_flag_d       = err_flag_q;
        timeout_d        = timeout_q;
`ifdef MEM_ENGINE_CHECKSUM_EN
        checksum_d       = checksum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d             = op_i;
                    addr_d           = base_i;
                    remain_d         = length_i;
                    pattern_d        = pattern_i;
                    wait_d           = 8'h0;
                    err_count_d      = 13'h0;
                    first_err_addr_d = 12'h0;
                    err_flag_d       = 1'b0;
                    timeout_d        = 1'b0;
`ifdef MEM_ENGINE_CHECKSUM_EN
                    checksum_d       = 32'h0;
`endif
                    state_d          = (length_i == 13'h0) ? StDone : StReq;
                end
            end
            StReq: begin
                if (ready_ok) begin
                    if (op_q && mismatch) begin
                        err_count_d = err_count_q + 13'd1;
                        if (!err_flag_q) begin
                            err_flag_d       = 1'b1;
                            first_err_addr_d = addr_q;
                        end
                    end
`ifdef MEM_ENGINE_CHECKSUM_EN
                    checksum_d = checksum_q + (op_q ? mem_read_data_i : expected);
`endif
                    state_d = StGap;
                end else if (wait_q == WaitLast) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StGap: begin
                remain_d = remain_q - 13'd1;
                addr_d   = addr_q + 12'd1;
                wait_d   = 8'h0;
                state_d  = (remain_q == 13'd1) ? StDone : StReq;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus and status outputs decode straight from registers; the reset-driven state drop
    // takes mem_cs_o low without waiting for a clock.
    assign busy_o           = (state_q == StReq) || (state_q == StGap);
    assign done_o           = (state_q == StDone);
    assign mem_cs_o         = (state_q == StReq);
    assign mem_we_o         = ((state_q == StReq) && !op_q) ? 4'hf : 4'h0;
    assign mem_address_o    = addr_q;
    assign mem_write_data_o = expected;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_addr_q;
    assign err_flag_o       = err_flag_q;
    assign timeout_o        = timeout_q;
`ifdef MEM_ENGINE_CHECKSUM_EN
    assign checksum_o       = checksum_q;
`endif

endmodule

// File: tb/tb_fpga_ram_engine.sv
`timescale 1ns/1ps
module tb_fpga_ram_engine;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [11:0] base;
    logic [12:0] length;
    logic [31:0] pattern;
    logic        busy;
    logic        done;
    logic [12:0] err_count;
    logic [11:0] first_err_addr;
    logic        err_flag;
    logic        timeout;
`ifdef MEM_ENGINE_CHECKSUM_EN
    logic [31:0] checksum;
`endif
    logic        mem_cs;
    logic [3:0]  mem_we;
    logic [11:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    always #5 clk = ~clk;

    fpga_ram_engine #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .op_i             (op),
        .base_i           (base),
        .length_i         (length),
        .pattern_i        (pattern),
        .busy_o           (busy),
        .done_o           (done),
        .err_count_o      (err_count),
        .first_err_addr_o (first_err_addr),
        .err_flag_o       (err_flag),
        .timeout_o        (timeout),
`ifdef MEM_ENGINE_CHECKSUM_EN
        .checksum_o       (checksum),
`endif
        .mem_cs_o         (mem_cs),
        .mem_we_o         (mem_we),
        .mem_address_o    (mem_address),
        .mem_write_data_o (mem_write_data),
        .mem_read_data_i  (mem_read_data),
        .mem_ready_i      (mem_ready)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [11:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        int          rel;
        logic [12:0] errs;
        logic [11:0] ffa;
        logic        flag;
        logic        to;
    } res_t;

    acc_t acc_q[$];
    res_t res_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic push_acc(input logic [11:0] a, input logic [3:0] w, input logic [31:0] d);
        acc_t e;
        e.addr = a;
        e.we   = w;
        e.data = d;
        acc_q.push_back(e);
    endtask

    task automatic push_res(input int rel, input logic [12:0] errs, input logic [11:0] ffa,
                            input logic flag, input logic to);
        res_t r;
        r.rel  = rel;
        r.errs = errs;
        r.ffa  = ffa;
        r.flag = flag;
        r.to   = to;
        res_q.push_back(r);
    endtask

    // ---------------- RAM responder ----------------
    // mode 0: ready one cycle after cs; 1: never ready; 2: ready stuck high
    int          mode = 0;
    logic [7:0]  cs_age;
    logic [31:0] ram [4096];

    always @(posedge clk or posedge rst) begin
        if (rst) cs_age <= 8'd0;
        else     cs_age <= mem_cs ? cs_age + 8'd1 : 8'd0;
    end

    assign mem_read_data = ram[mem_address];
    assign mem_ready     = (mode == 0) ? (mem_cs && cs_age != 8'd0) : (mode == 2);

    // ---------------- cycle counter ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int start_cyc = 0;
    int done_cnt  = 0;
    int cs_total  = 0;
    int abort_run = 0;

    // ---------------- monitor ----------------
    initial begin
        logic        prev_cs;
        int          run_len;
        logic [11:0] run_addr;
        logic [3:0]  run_we;
        logic [31:0] run_data;
        logic        run_stable;
        logic        last_ready;
        acc_t        e;
        res_t        r;
        prev_cs    = 1'b0;
        run_len    = 0;
        run_addr   = '0;
        run_we     = '0;
        run_data   = '0;
        run_stable = 1'b1;
        last_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_cs) begin
                if (!prev_cs) begin
                    run_len    = 0;
                    run_addr   = mem_address;
                    run_we     = mem_we;
                    run_data   = mem_write_data;
                    run_stable = 1'b1;
                end else if (mem_address !== run_addr || mem_we !== run_we ||
                             mem_write_data !== run_data) begin
                    run_stable = 1'b0;
                end
                run_len++;
                cs_total++;
                last_ready = mem_ready;
            end else if (prev_cs) begin
                if (busy) begin
                    // cs fell into GAP: one access completed
                    check("access held stable", 32'(run_stable), 32'd1);
                    check("access spans >=2 cs cycles", 32'(run_len >= 2), 32'd1);
                    check("access ended with ready", 32'(last_ready), 32'd1);
                    if (acc_q.size() == 0) begin
                        fail("unexpected access");
                    end else begin
                        e = acc_q.pop_front();
                        check("access addr", 32'(run_addr), 32'(e.addr));
                        check("access we", 32'(run_we), 32'(e.we));
                        if (e.we == 4'hf) check("access wdata", run_data, e.data);
                    end
                    if (run_we == 4'hf) ram[run_addr] = run_data;
                end else begin
                    abort_run = run_len;
                end
            end
            prev_cs = mem_cs;
            if (done) begin
                done_cnt++;
                if (res_q.size() == 0) begin
                    fail("unexpected done pulse");
                end else begin
                    r = res_q.pop_front();
                    check("done cycle", 32'(cyc - start_cyc), 32'(r.rel));
                    check("err_count", 32'(err_count), 32'(r.errs));
                    check("first_err_addr", 32'(first_err_addr), 32'(r.ffa));
                    check("err_flag", 32'(err_flag), 32'(r.flag));
                    check("timeout", 32'(timeout), 32'(r.to));
                    check("cs low at done", 32'(mem_cs), 32'd0);
                    check("busy low at done", 32'(busy), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic o, input logic [11:0] b, input logic [12:0] l,
                         input logic [31:0] p);
        @(posedge clk);
        #1;
        start     = 1'b1;
        op        = o;
        base      = b;
        length    = l;
        pattern   = p;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) fail({name, " done wait expired"});
        check({name, " expected accesses consumed"}, 32'(acc_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int cs0;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 1'b0;
        base    = '0;
        length  = '0;
        pattern = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        check("reset first_err_addr", 32'(first_err_addr), 32'd0);
        check("reset err_flag", 32'(err_flag), 32'd0);
        check("reset timeout", 32'(timeout), 32'd0);
        check("reset mem_cs", 32'(mem_cs), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_address", 32'(mem_address), 32'd0);
        check("reset mem_write_data", mem_write_data, 32'd0);
`ifdef MEM_ENGINE_CHECKSUM_EN
        check("reset checksum", checksum, 32'd0);
`endif
        rst = 1'b0;

        // FILL 0x000, 4 words
        push_acc(12'h000, 4'hf, 32'hA5A5_0000);
        push_acc(12'h001, 4'hf, 32'hA5A5_0001);
        push_acc(12'h002, 4'hf, 32'hA5A5_0002);
        push_acc(12'h003, 4'hf, 32'hA5A5_0003);
        push_res(13, 13'd0, 12'h000, 1'b0, 1'b0);
        issue(1'b0, 12'h000, 13'd4, 32'hA5A5_0000);
        wait_done(1, "fill1");
`ifdef MEM_ENGINE_CHECKSUM_EN
        check("fill1 checksum", checksum, 32'h9694_0006);
`endif

        // CHECK with word 2 corrupted
        ram[2] = 32'h0;
        for (int i = 0; i < 4; i++) push_acc(12'(i), 4'h0, 32'h0);
        push_res(13, 13'd1, 12'h002, 1'b1, 1'b0);
        issue(1'b1, 12'h000, 13'd4, 32'hA5A5_0000);
        wait_done(2, "check1");

        // CHECK with words 1 and 2 corrupted: first error address is the earlier one
        ram[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) push_acc(12'(i), 4'h0, 32'h0);
        push_res(13, 13'd2, 12'h001, 1'b1, 1'b0);
        issue(1'b1, 12'h000, 13'd4, 32'hA5A5_0000);
        wait_done(3, "check2");

        // length 0: immediate done, results cleared, no bus activity
        cs0 = cs_total;
        push_res(1, 13'd0, 12'h000, 1'b0, 1'b0);
        issue(1'b1, 12'h123, 13'd0, 32'hFFFF_FFFF);
        wait_done(4, "len0");
        check("len0 no cs cycles", 32'(cs_total - cs0), 32'd0);

        // FILL with address wrap
        push_acc(12'hFFE, 4'hf, 32'h1234_0FFE);
        push_acc(12'hFFF, 4'hf, 32'h1234_0FFF);
        push_acc(12'h000, 4'hf, 32'h1234_0000);
        push_acc(12'h001, 4'hf, 32'h1234_0001);
        push_res(13, 13'd0, 12'h000, 1'b0, 1'b0);
        issue(1'b0, 12'hFFE, 13'd4, 32'h1234_0000);
        wait_done(5, "fillwrap");

        // responder never ready: timeout abort, ignored start while busy
        mode = 1;
        push_res(TO + 1, 13'd0, 12'h000, 1'b0, 1'b1);
        issue(1'b0, 12'h010, 13'd3, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        op     = 1'b1;
        length = 13'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, "timeout");
        check("timeout stalled cs cycles", 32'(abort_run), 32'(TO));
        repeat (5) @(posedge clk);
        #1;
        check("timeout single done", 32'(done_cnt), 32'd6);
        check("timeout cs low after abort", 32'(mem_cs), 32'd0);
        check("timeout flag held", 32'(timeout), 32'd1);

        // stale ready stuck high: CHECK of the wrapped window
        mode = 2;
        push_acc(12'hFFE, 4'h0, 32'h0);
        push_acc(12'hFFF, 4'h0, 32'h0);
        push_acc(12'h000, 4'h0, 32'h0);
        push_acc(12'h001, 4'h0, 32'h0);
        push_res(13, 13'd0, 12'h000, 1'b0, 1'b0);
        issue(1'b1, 12'hFFE, 13'd4, 32'h1234_0000);
        wait_done(7, "stale");

        // reset in the middle of a long FILL
        mode = 0;
        for (int i = 0; i < 100; i++)
            push_acc(12'h100 + 12'(i), 4'hf, 32'h5555_0000 ^ (32'h100 + 32'(i)));
        issue(1'b0, 12'h100, 13'd100, 32'h5555_0000);
        repeat (7) @(posedge clk);
        #3;
        check("midreset cs high before reset", 32'(mem_cs), 32'd1);
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        check("midreset cs drops", 32'(mem_cs), 32'd0);
        check("midreset busy drops", 32'(busy), 32'd0);
        acc_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset no done", 32'(done_cnt), 32'(d0));
        check("midreset address cleared", 32'(mem_address), 32'd0);

        // FILL after reset
        push_acc(12'h000, 4'hf, 32'h0000_0010);
        push_acc(12'h001, 4'hf, 32'h0000_0011);
        push_res(7, 13'd0, 12'h000, 1'b0, 1'b0);
        issue(1'b0, 12'h000, 13'd2, 32'h0000_0010);
        wait_done(d0 + 1, "postreset");
`ifdef MEM_ENGINE_CHECKSUM_EN
        check("postreset checksum", checksum, 32'h0000_0021);
`endif
        check("no pending results", 32'(res_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
